// File: rtl/mcp3_arb_pkg.sv
// rtl/mcp3_arb_pkg.sv - shared types and widths for the 512-way arbiter command controller
package mcp3_arb_pkg;
    localparam int WIN_W  = 9;
    localparam int CRED_W = 6;
    localparam int PERF_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } ctl_state_e;
endpackage

// File: rtl/mcp3_arb512_ctl_if.sv
// rtl/mcp3_arb512_ctl_if.sv - arbiter winner and downstream command handshake bundle
interface mcp3_arb512_ctl_if;
    import mcp3_arb_pkg::*;

    logic             arb_valid;
    logic [WIN_W-1:0] arb_winner;
    logic             arb_taken;
    logic             cmd_valid;
    logic [WIN_W-1:0] cmd_tag;
    logic             cmd_ready;

    modport master (
        input  arb_valid, arb_winner, cmd_ready,
        output arb_taken, cmd_valid, cmd_tag
    );

    modport slave (
        output arb_valid, arb_winner, cmd_ready,
        input  arb_taken, cmd_valid, cmd_tag
    );
endinterface

// File: rtl/mcp3_credit_cnt.sv
// rtl/mcp3_credit_cnt.sv - outstanding-command credit counter with sticky overflow flag
module mcp3_credit_cnt
    import mcp3_arb_pkg::*;
#(
    parameter int MAX_CREDITS = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dec,
    input  logic              inc,
    output logic [CRED_W-1:0] count,
    output logic              ovf
);
    localparam logic [CRED_W-1:0] MAX_C = CRED_W'(MAX_CREDITS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= MAX_C;
            ovf   <= 1'b0;
        end else begin
            unique case ({inc, dec})
                2'b01: if (count != '0) count <= count - 1'b1;
                // A return with no room is dropped but remembered until reset.
                2'b10: begin
                    if (count == MAX_C) ovf <= 1'b1;
                    else                count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mcp3_arb512_ctl.sv
// rtl/mcp3_arb512_ctl.sv - credit-gated grant/issue controller for a 512-way arbiter
// Optional perf counters build with MCP3_ARB512_CTL_PERF_EN.
module mcp3_arb512_ctl
    import mcp3_arb_pkg::*;
#(
    parameter int MAX_CREDITS = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    mcp3_arb512_ctl_if.master    bus,
    input  logic                 ctl_enable,
    input  logic                 cred_return,
    output logic [CRED_W-1:0]    credits_avail,
    output logic                 ctl_idle,
    output logic                 err_cred_ovf
`ifdef MCP3_ARB512_CTL_PERF_EN
    ,
    input  logic                 perf_clear,
    output logic [PERF_W-1:0]    perf_grant_cnt,
    output logic [PERF_W-1:0]    perf_stall_cnt
`endif
);
    localparam logic [CRED_W-1:0] MAX_C = CRED_W'(MAX_CREDITS);

    ctl_state_e       state;
    logic             cmd_valid_q;
    logic [WIN_W-1:0] cmd_tag_q;
    logic             taken;

    // In ISSUE a new winner is only taken when the current command leaves.
    assign taken = !reset && bus.arb_valid && ctl_enable && (credits_avail != '0)
                   && ((state == IDLE) || bus.cmd_ready);

    assign bus.arb_taken = taken;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_tag   = cmd_tag_q;
    assign ctl_idle      = (state == IDLE) && (credits_avail == MAX_C);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cmd_valid_q <= 1'b0;
            cmd_tag_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (taken) begin
                        cmd_tag_q   <= bus.arb_winner;
                        cmd_valid_q <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.cmd_ready) begin
                        if (taken) begin
                            cmd_tag_q <= bus.arb_winner;
                        end else begin
                            cmd_valid_q <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    mcp3_credit_cnt #(.MAX_CREDITS(MAX_CREDITS)) u_credit_cnt (
        .clock (clock),
        .reset (reset),
        .dec   (taken),
        .inc   (cred_return),
        .count (credits_avail),
        .ovf   (err_cred_ovf)
    );

`ifdef MCP3_ARB512_CTL_PERF_EN
    logic stall;
    assign stall = bus.arb_valid && ctl_enable && (credits_avail == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else if (perf_clear) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (taken && (perf_grant_cnt != '1)) perf_grant_cnt <= perf_grant_cnt + 1'b1;
            if (stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: doc/mcp3_arb512_ctl.md
MCP3_ARB512_CTL -- requirements
Module: mcp3_arb512_ctl

Interface
REQ-001 SHALL have parameter MAX_CREDITS, default 16, giving the number of outstanding commands allowed (range 1..63).
REQ-002 SHALL have port clock, input, 1, the single clock for all state.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port ctl_enable, input, 1; high permits new grants.
REQ-005 SHALL have port arb_valid, input, 1; the 512-way arbiter has a winner.
REQ-006 SHALL have port arb_winner, input, 9; the encoded winner index from the 512-way arbiter.
REQ-007 SHALL have port arb_taken, output, 1; one-cycle pulse that consumes and clears the arbiter winner.
REQ-008 SHALL have port cmd_valid, output, 1; a command is presented downstream.
REQ-009 SHALL have port cmd_tag, output, 9; the winner index of the presented command.
REQ-010 SHALL have port cmd_ready, input, 1; downstream accepts the command.
REQ-011 SHALL have port cred_return, input, 1; one credit returned per cycle asserted.
REQ-012 SHALL have port credits_avail, output, 6; the current credit count.
REQ-013 SHALL have port ctl_idle, output, 1; high when in IDLE with credits_avail equal to MAX_CREDITS.
REQ-014 SHALL have port err_cred_ovf, output, 1; sticky flag set on a credit return at maximum.

Function
REQ-015 SHALL implement FSM states IDLE and ISSUE.
REQ-016 SHALL assert arb_taken, combinationally, when all four hold: arb_valid, ctl_enable, credits_avail>0, and (state IDLE or (state ISSUE and cmd_ready)).
REQ-017 SHALL, on arb_taken, register arb_winner into cmd_tag, set cmd_valid the next cycle, and enter ISSUE; latency is 1 cycle from arb_valid to cmd_valid.
REQ-018 SHALL hold cmd_valid and cmd_tag stable in ISSUE until cmd_ready is sampled high.
REQ-019 SHALL, in ISSUE, do the following on cmd_ready: with arb_taken in the same cycle, load the new tag and stay in ISSUE (back-to-back, no bubble); otherwise clear cmd_valid and go to IDLE.
REQ-020 SHALL decrement credits on arb_taken and increment on cred_return; if both occur in the same cycle, the count is unchanged.
REQ-021 SHALL never assert arb_taken while credits_avail==0; arbitration stalls until a credit returns.
REQ-022 SHALL ignore cred_return when credits_avail==MAX_CREDITS without a same-cycle decrement, and SHALL set err_cred_ovf, which holds until reset.
REQ-023 SHALL, when ctl_enable falls during ISSUE, complete the pending command normally and take no new winners.
REQ-024 SHALL ignore arb_winner when arb_valid is low.

Reset
REQ-025 SHALL, on reset assertion, asynchronously force: state IDLE, cmd_valid 0, cmd_tag 0, credits_avail MAX_CREDITS, err_cred_ovf 0, and arb_taken 0.
REQ-026 SHALL drop any in-flight command when reset asserts mid-ISSUE; no replay follows reset release.

Configuration
REQ-027 SHALL, with MCP3_ARB512_CTL_PERF_EN defined, add ports perf_clear (input 1), perf_grant_cnt (output 32) and perf_stall_cnt (output 32).
REQ-028 SHALL, with the macro defined, count arb_taken pulses in perf_grant_cnt, and count in perf_stall_cnt the cycles with arb_valid and ctl_enable high but credits_avail==0; both saturate at all-ones, clear synchronously on perf_clear, and reset to 0.
REQ-029 SHALL, without the macro, have neither the ports nor the counter logic, and SHALL leave all other behaviour identical.

Structure
REQ-030 SHALL take the following from shared package mcp3_arb_pkg: the state enum (IDLE, ISSUE), the winner width constant (9), the credit width constant (6) and the perf counter width (32).
REQ-031 SHALL implement the credit counter as sub-module mcp3_credit_cnt, covering increment, decrement, saturation and overflow flag.

Verification
REQ-032 SHALL cover: after reset, arb_valid=1, arb_winner=0x1A5, cmd_ready=1 -> arb_taken in cycle 0, then cmd_valid=1 and cmd_tag=0x1A5 in cycle 1, with credits_avail=15.
REQ-033 SHALL cover: cmd_ready held 0 for 5 cycles with arb_valid=1 -> arb_taken stays 0 and cmd_tag stays stable; when cmd_ready rises, arb_taken pulses in that same cycle and the next tag follows with no bubble.
REQ-034 SHALL cover: MAX_CREDITS=4, no returns, continuous requests -> exactly 4 grants, then credits_avail=0 and arb_taken=0; one cred_return -> exactly one further grant.
REQ-035 SHALL cover: cred_return and arb_taken in the same cycle at credits_avail=3 -> credits_avail=3 next cycle.
REQ-036 SHALL cover: cred_return at credits_avail=16 -> credits_avail remains 16 and err_cred_ovf=1 until reset.
REQ-037 SHALL cover: reset asserted mid-ISSUE with cmd_tag=0x0FF -> cmd_valid=0 immediately (asynchronous), and ctl_idle=1 after release; with PERF_EN, 10 stall cycles give perf_stall_cnt=10.
